// File: rtl/imm_pkg.sv
// Shared types and constants for the LEGv8 immediate issue controller.
package imm_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned IMM_W   = 64;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_B    = 3'd1,
    FMT_CB   = 3'd2,
    FMT_D    = 3'd3,
    FMT_I    = 3'd4
  } fmt_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Opcode fields, matched most specific first by the decoder.
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [9:0]  OP_ADDIS = 10'b1011000100;
  localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
  localparam logic [9:0]  OP_SUBIS = 10'b1111000100;

endpackage

// File: rtl/imm_issue_ctrl_if.sv
// Input word stream and output immediate stream of imm_issue_ctrl.
interface imm_issue_ctrl_if;
  import imm_pkg::*;

  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [IMM_W-1:0]   out_imm;
  fmt_t               out_fmt;

  // Producer of instruction words and consumer of results.
  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt
  );

  // The controller itself.
  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt
  );

endinterface

// File: rtl/imm_fmt_decode.sv
// Combinational LEGv8 immediate decode and extension.
// Optional macro IMM_BRANCH_SHIFT_EN: branch offsets become byte offsets (<<2).
module imm_fmt_decode
  import imm_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [IMM_W-1:0]   imm,
  output fmt_t               fmt
);

  // Priority opcode match, then sign/zero extension of the selected field.
  always_comb begin
    imm = '0;
    fmt = FMT_NONE;
    if (instr[31:26] == OP_B || instr[31:26] == OP_BL) begin
      fmt = FMT_B;
      imm = {{38{instr[25]}}, instr[25:0]};
    end else if (instr[31:24] == OP_CBZ || instr[31:24] == OP_CBNZ ||
                 instr[31:24] == OP_BCOND) begin
      fmt = FMT_CB;
      imm = {{45{instr[23]}}, instr[23:5]};
    end else if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR) begin
      fmt = FMT_D;
      imm = {{55{instr[20]}}, instr[20:12]};
    end else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_ADDIS ||
                 instr[31:22] == OP_SUBI || instr[31:22] == OP_SUBIS) begin
      fmt = FMT_I;
      imm = {52'd0, instr[21:10]};
    end
`ifdef IMM_BRANCH_SHIFT_EN
    if (fmt == FMT_B || fmt == FMT_CB) begin
      imm = {imm[IMM_W-3:0], 2'b00};
    end
`endif
  end

endmodule

// File: rtl/imm_issue_ctrl.sv
// Immediate issue controller: decode stage with a two-entry output/skid buffer.
// Optional macro IMM_BRANCH_SHIFT_EN is honoured by imm_fmt_decode.
module imm_issue_ctrl
  import imm_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  imm_issue_ctrl_if.slave bus
);

  logic [IMM_W-1:0] dec_imm;
  fmt_t             dec_fmt;

  state_t           state;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [IMM_W-1:0] out_imm_q;
  fmt_t             out_fmt_q;
  logic [IMM_W-1:0] skid_imm_q;
  fmt_t             skid_fmt_q;

  logic accept;
  logic drain;

  imm_fmt_decode u_dec (
    .instr (bus.in_instr),
    .imm   (dec_imm),
    .fmt   (dec_fmt)
  );

  assign accept = bus.in_valid && in_ready_q;
  assign drain  = out_valid_q && bus.out_ready;

  // Buffer occupancy FSM; in_ready is registered from the next state so it never depends on out_ready combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_imm_q   <= '0;
      out_fmt_q   <= FMT_NONE;
      skid_imm_q  <= '0;
      skid_fmt_q  <= FMT_NONE;
    end else begin
      in_ready_q <= 1'b1;
      case (state)
        EMPTY: begin
          if (accept) begin
            out_imm_q   <= dec_imm;
            out_fmt_q   <= dec_fmt;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (accept && !drain) begin
            skid_imm_q <= dec_imm;
            skid_fmt_q <= dec_fmt;
            in_ready_q <= 1'b0;
            state      <= FULL;
          end else if (accept && drain) begin
            out_imm_q <= dec_imm;
            out_fmt_q <= dec_fmt;
          end else if (drain) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            out_imm_q <= skid_imm_q;
            out_fmt_q <= skid_fmt_q;
            state     <= ONE;
          end else begin
            in_ready_q <= 1'b0;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state       <= EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = out_imm_q;
  assign bus.out_fmt   = out_fmt_q;

endmodule

// File: tb/tb_imm_issue_ctrl.sv
// Directed self-checking bench for imm_issue_ctrl.
module tb_imm_issue_ctrl;
  import imm_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  imm_issue_ctrl_if bus ();

  imm_issue_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef IMM_BRANCH_SHIFT_EN
  localparam logic [63:0] EXP_B  = 64'hFFFFFFFFFFFFFFFC;
  localparam logic [63:0] EXP_CB = 64'h40;
`else
  localparam logic [63:0] EXP_B  = 64'hFFFFFFFFFFFFFFFF;
  localparam logic [63:0] EXP_CB = 64'h10;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one word into an empty controller and check the result one cycle later.
  task automatic single(input string tag, input logic [31:0] instr,
                        input logic [63:0] exp_imm, input fmt_t exp_fmt);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = instr;
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, "_imm"}, bus.out_imm, exp_imm);
    chk({tag, "_fmt"}, 64'(bus.out_fmt), 64'(exp_fmt));
    tick();
    chk({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_imm", bus.out_imm, 64'd0);
    chk("rst_out_fmt", 64'(bus.out_fmt), 64'(FMT_NONE));
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Individual formats, 1-cycle latency
    single("b_neg1", 32'h17FFFFFF, EXP_B, FMT_B);
    single("cbz_16", 32'hB4000200, EXP_CB, FMT_CB);
    single("ldur_neg", 32'hF8500000, 64'hFFFFFFFFFFFFFF00, FMT_D);
    single("addi_fff", 32'h913FFC00, 64'h0000000000000FFF, FMT_I);
    single("none_zero", 32'h00000000, 64'd0, FMT_NONE);

    // Backpressure: three words, consumer stalled for three cycles
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h91000400;
    tick();
    chk("bp_rdy_after1", 64'(bus.in_ready), 64'd1);
    bus.in_instr = 32'h91000800;
    tick();
    chk("bp_rdy_after2", 64'(bus.in_ready), 64'd0);
    chk("bp_hold1_imm", bus.out_imm, 64'd1);
    bus.in_instr = 32'h91000C00;
    tick();
    chk("bp_rdy_stall", 64'(bus.in_ready), 64'd0);
    chk("bp_hold2_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_hold2_imm", bus.out_imm, 64'd1);
    chk("bp_hold2_fmt", 64'(bus.out_fmt), 64'(FMT_I));
    bus.out_ready = 1'b1;
    tick();
    chk("bp_out2_imm", bus.out_imm, 64'd2);
    chk("bp_out2_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_rdy_reopen", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_out3_imm", bus.out_imm, 64'd3);
    chk("bp_out3_valid", 64'(bus.out_valid), 64'd1);
    tick();
    chk("bp_done_valid", 64'(bus.out_valid), 64'd0);

    // Streaming: eight words, one result per cycle
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      bus.in_instr = 32'h91000000 | (32'(k) << 10);
      tick();
      chk("stream_valid", 64'(bus.out_valid), 64'd1);
      chk("stream_imm", bus.out_imm, 64'(k));
      chk("stream_rdy", 64'(bus.in_ready), 64'd1);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream_end_valid", 64'(bus.out_valid), 64'd0);

    // Reset while FULL discards both entries
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h91001400;
    tick();
    bus.in_instr = 32'h91001800;
    tick();
    chk("full_rdy", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_rdy", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_imm", bus.out_imm, 64'd0);
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("rerst_rdy", 64'(bus.in_ready), 64'd1);
    chk("rerst_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("rerst_no_stale", 64'(bus.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_issue_ctrl.md
IMM_ISSUE_CTRL -- requirements
Module: imm_issue_ctrl

Interface
REQ-001 The module SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Port `clk`, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 Port `reset`, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port `in_valid`, input, 1 bit: `in_instr` is presented.
REQ-005 Port `in_instr`, input, 32 bits: LEGv8 instruction word.
REQ-006 Port `in_ready`, output, 1 bit: the block accepts a word this cycle.
REQ-007 Port `out_valid`, output, 1 bit: `out_imm` and `out_fmt` hold a result.
REQ-008 Port `out_ready`, input, 1 bit: the consumer takes the result this cycle.
REQ-009 Port `out_imm`, output, 64 bits: the extended immediate.
REQ-010 Port `out_fmt`, output, 3 bits: format tag from `imm_pkg::fmt_t`.

Function
REQ-011 Accept an input on a cycle with `in_valid` && `in_ready`; deliver an output on a cycle with `out_valid` && `out_ready`.
REQ-012 Decode by opcode, most specific match first:
- B/BL: `[31:26]` is 000101 or 100101 -> FMT_B; imm26 = `[25:0]`, sign-extended.
- CBZ/CBNZ/B.cond: `[31:24]` is 10110100, 10110101 or 01010100 -> FMT_CB; imm19 = `[23:5]`, sign-extended.
- LDUR/STUR: `[31:21]` is 11111000010 or 11111000000 -> FMT_D; imm9 = `[20:12]`, sign-extended.
- ADDI/ADDIS/SUBI/SUBIS: `[31:22]` is 1001000100, 1011000100, 1101000100 or 1111000100 -> FMT_I; imm12 = `[21:10]`, zero-extended.
- Any other word -> FMT_NONE with `out_imm` = 0.
REQ-013 Latency SHALL be exactly 1 cycle: a word accepted in cycle N appears on `out_*` in cycle N+1 when the output register is empty or is drained in cycle N.
REQ-014 Buffering SHALL be 2 entries: output register plus skid register.
- `in_ready` = !skid_full; it is registered, with no combinational path from `out_ready`.
REQ-015 The state machine SHALL have states EMPTY, ONE (output register valid) and FULL (output register and skid valid).
- EMPTY: accept -> ONE.
- ONE: accept without drain -> FULL; drain without accept -> EMPTY; accept with drain, or neither -> ONE.
- FULL: drain -> ONE and skid moves to the output register in the same cycle; no accept is possible in FULL.
REQ-016 Results SHALL be delivered in strict acceptance order, with none lost or duplicated.
REQ-017 While `out_valid` is high and `out_ready` is low, `out_imm` and `out_fmt` SHALL hold stable.
REQ-018 A simultaneous accept and drain in ONE SHALL load the new result directly into the output register.

Reset
REQ-019 While `reset` is high, outputs SHALL be: `out_valid` = 0, `out_imm` = 0, `out_fmt` = FMT_NONE, `in_ready` = 0; state SHALL be EMPTY with skid cleared.
REQ-020 On the first rising edge of `clk` after `reset` falls, `in_ready` SHALL rise to 1.
REQ-021 Reset asserted mid-operation SHALL discard buffered entries without emitting them.

Configuration
REQ-022 Macro `IMM_BRANCH_SHIFT_EN` defined: FMT_B and FMT_CB immediates SHALL be shifted left by 2 after sign extension, giving a byte offset.
REQ-023 Macro `IMM_BRANCH_SHIFT_EN` undefined: FMT_B and FMT_CB immediates SHALL be the unshifted word offset; FMT_D and FMT_I are unaffected in both cases.

Structure
REQ-024 Package `imm_pkg` SHALL hold `fmt_t` (FMT_NONE = 0, FMT_B = 1, FMT_CB = 2, FMT_D = 3, FMT_I = 4), the opcode constants, and the state enum.
REQ-025 Decode and extension SHALL be one combinational sub-module, `imm_fmt_decode` (input `instr`; outputs `imm` and `fmt`), instantiated once before the output/skid registers.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- B with imm26 = 26'h3FFFFFF -> `out_imm` = 64'hFFFFFFFFFFFFFFFF without the macro, 64'hFFFFFFFFFFFFFFFC with it; `out_fmt` = FMT_B; 1-cycle latency.
- CBZ with imm19 = 19'h00010 -> 64'h10, or 64'h40 with the macro; LDUR with imm9 = 9'h100 -> 64'hFFFFFFFFFFFFFF00, FMT_D.
- ADDI with imm12 = 12'hFFF -> 64'h0000000000000FFF, FMT_I; word 32'h00000000 -> FMT_NONE, `out_imm` = 0.
- Three back-to-back inputs with `out_ready` low for 3 cycles -> `in_ready` low after 2 accepts, outputs held stable; release `out_ready` -> all 3 emitted in order on consecutive cycles.
- Continuous `in_valid` and `out_ready` for 8 words -> one result per cycle, `in_ready` stays 1.
- Assert `reset` in FULL -> `out_valid` = 0 immediately; after release no stale result appears and `in_ready` = 1 one cycle later.
